// File: rtl/rps_pkg.sv
// Shared parameters, green-hand thresholds and state encoding for the
// rock-paper-scissors classifier front end.
package rps_pkg;

    localparam int LENGTH = 30;
    localparam int WIDTH  = 40;
    localparam int LEFT   = 20;

    localparam logic [7:0] LOWER_GREEN_0 = 8'd16;
    localparam logic [7:0] UPPER_GREEN_0 = 8'd100;
    localparam logic [7:0] LOWER_GREEN_1 = 8'd120;
    localparam logic [7:0] UPPER_GREEN_1 = 8'd250;
    localparam logic [7:0] LOWER_GREEN_2 = 8'd16;
    localparam logic [7:0] UPPER_GREEN_2 = 8'd100;

    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(LENGTH);

    typedef enum logic [1:0] {IDLE, SCAN, STRIP, DONE} state_t;

endpackage

// File: rtl/green_pixel_filter.sv
// Combinational green-hand threshold: a pixel passes iff every channel lies
// inside its inclusive bound.
module green_pixel_filter
    import rps_pkg::*;
(
    input  logic [23:0] pixel,
    output logic        g
);

    assign g = (pixel[7:0]   >= LOWER_GREEN_0) && (pixel[7:0]   <= UPPER_GREEN_0) &&
               (pixel[15:8]  >= LOWER_GREEN_1) && (pixel[15:8]  <= UPPER_GREEN_1) &&
               (pixel[23:16] >= LOWER_GREEN_2) && (pixel[23:16] <= UPPER_GREEN_2);

endmodule

// File: rtl/hand_scan_ctrl.sv
// Per-frame hand-pixel scan: thresholds a raster pixel stream, accumulates
// sums and column occupancy, then extracts the leftmost occupied column.
module hand_scan_ctrl #(
    parameter int LENGTH = rps_pkg::LENGTH,
    parameter int WIDTH  = rps_pkg::WIDTH,
    parameter int LEFT   = rps_pkg::LEFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [23:0]              pix_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_sum,
    output logic [31:0]              res_sum_left,
    output logic                     res_found,
    output logic [$clog2(WIDTH)-1:0] res_leftmost,
    output logic [LENGTH-1:0]        res_strip,
    output logic                     busy
);

    import rps_pkg::*;

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(LENGTH);
    localparam int KW = $clog2(LENGTH + 1);

    state_t                         state;
    logic [RW-1:0]                  row;
    logic [CW-1:0]                  col;
    logic [KW-1:0]                  k;
    logic [31:0]                    sum;
    logic [31:0]                    sum_left;
    logic [WIDTH-1:0]               colmap;
    logic [LENGTH-1:0][WIDTH-1:0]   mask;

    logic          g;
    logic          take;
    logic          last_col;
    logic          last_row;
    logic [CW-1:0] first_col;
    logic          any_col;
    logic [RW-1:0] strip_row;

    green_pixel_filter u_filter (
        .pixel (pix_data),
        .g     (g)
    );

    assign take      = pix_valid && pix_ready;
    assign last_col  = (col == CW'(WIDTH - 1));
    assign last_row  = (row == RW'(LENGTH - 1));
    assign strip_row = RW'(k - KW'(1));

    // Lowest set column wins; first_col stays 0 when the map is empty.
    always_comb begin
        first_col = '0;
        any_col   = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (colmap[i] && !any_col) begin
                first_col = CW'(i);
                any_col   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            k            <= '0;
            sum          <= '0;
            sum_left     <= '0;
            colmap       <= '0;
            mask         <= '0;
            pix_ready    <= 1'b0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
            res_sum      <= '0;
            res_sum_left <= '0;
            res_found    <= 1'b0;
            res_leftmost <= '0;
            res_strip    <= '0;
        end else if (abort) begin
            state     <= IDLE;
            pix_ready <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= SCAN;
                        pix_ready    <= 1'b1;
                        busy         <= 1'b1;
                        row          <= '0;
                        col          <= '0;
                        sum          <= '0;
                        sum_left     <= '0;
                        colmap       <= '0;
                        mask         <= '0;
                        res_sum      <= '0;
                        res_sum_left <= '0;
                        res_found    <= 1'b0;
                        res_leftmost <= '0;
                        res_strip    <= '0;
                    end
                end
                SCAN: begin
                    if (take) begin
                        mask[row][col] <= g;
                        sum            <= sum + 32'(g);
                        if (int'(col) < LEFT)
                            sum_left <= sum_left + 32'(g);
                        colmap[col] <= colmap[col] | g;
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                state     <= STRIP;
                                pix_ready <= 1'b0;
                                k         <= '0;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                STRIP: begin
                    if (k == '0) begin
                        res_leftmost <= first_col;
                        res_found    <= any_col;
                        res_sum      <= sum;
                        res_sum_left <= sum_left;
                    end else begin
                        res_strip[strip_row] <= mask[strip_row][res_leftmost];
                    end
                    if (k == KW'(LENGTH)) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hand_scan_ctrl.md
# hand_scan_ctrl

Sequencing controller for the rock-paper-scissors classifier front end. It accepts one RGB pixel per cycle in raster order over a valid/ready stream and applies the green-hand threshold to each pixel. Per frame it accumulates the total hand-pixel count, the count in the left region and a per-column occupancy map. After the last pixel it finds the leftmost occupied column, extracts that column as a vertical strip, and presents everything as a single result record over a valid/ready handshake to the downstream classifier logic.

## Interface
Parameters (defaults come from `rps_pkg`):
- `LENGTH`, 30: image rows.
- `WIDTH`, 40: image columns.
- `LEFT`, 20: columns `0..LEFT-1` form the left region; `LEFT <= WIDTH`.

Ports (all signals synchronous to `clk`; one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a frame; honoured only in IDLE.
- `abort` in 1: synchronous; forces a return to IDLE from any state.
- `pix_valid` in 1: pixel present.
- `pix_ready` out 1: controller accepts a pixel.
- `pix_data` in 24: channel 2 in `[23:16]`, channel 1 in `[15:8]`, channel 0 in `[7:0]`.
- `res_valid` out 1: result record valid.
- `res_ready` in 1: consumer accepts the record.
- `res_sum` out 32: total hand-pixel count.
- `res_sum_left` out 32: hand-pixel count in columns `< LEFT`.
- `res_found` out 1: at least one hand pixel was present in the frame.
- `res_leftmost` out `COL_W`: lowest occupied column index; 0 if none.
- `res_strip` out `LENGTH`: bit `r` is the mask at row `r`, column `res_leftmost`.
- `busy` out 1: state is not IDLE.

## Operation
States and transitions:
- IDLE:
  - `pix_ready`=0.
  - `start` && !`abort` → SCAN.
  - Entering SCAN clears the row/column counters, both sums, the column map, the mask buffer and `res_*`.
- SCAN:
  - `pix_ready`=1.
  - Each handshake (`pix_valid && pix_ready`):
    - `g` = green_pixel_filter(`pix_data`).
    - `mask[row][col] <= g`.
    - `sum += g`.
    - `sum_left += g` if `col < LEFT`.
    - `colmap[col] |= g`.
  - Column increments. At `WIDTH-1` it wraps to 0 and the row increments.
  - The handshake at (`LENGTH-1`, `WIDTH-1`) → STRIP.
  - No handshake: all state holds.
- STRIP (`LENGTH+1` cycles, internal counter `k`):
  - `k`=0: priority-encode `colmap`, lowest set index first; latch `res_leftmost`, `res_found`.
  - `k`=1..`LENGTH`: `res_strip[k-1] <= mask[k-1][res_leftmost]`.
  - After `k`=`LENGTH` → DONE.
- DONE:
  - `res_valid`=1; all `res_*` stable.
  - `res_ready` → IDLE.
  - `res_*` hold their values until the next `start`.
- `abort` in any state → IDLE on the next edge. `res_valid` drops. Partial results are discarded at the next `start`.

Arithmetic and boundary rules:
- Sums are unsigned and never wrap, since `LENGTH*WIDTH < 2^32`.
- The filter passes a pixel iff every channel lies in its inclusive package bound.
- Frame with no hand pixels: `res_found`=0, `res_leftmost`=0, `res_strip`=0 (column 0 has no set bits).
- `start` while not IDLE is ignored.
- `start` and `abort` in the same cycle in IDLE: `abort` wins and the state stays IDLE.

## Timing
- All outputs reset to 0: `pix_ready`, `res_valid`, `busy`, all `res_*`.
- `pix_ready` rises the cycle after the `start` edge. It falls the cycle after the final-pixel handshake; no pixel is accepted after the last one.
- Throughput in SCAN is 1 pixel per cycle with `pix_valid` held high.
- `res_valid` rises exactly `LENGTH+1` edges after the edge that accepts the final pixel.
- Result handshake: the record transfers on the edge where `res_valid && res_ready`. `res_valid` is low the next cycle. `res_ready` held high before `res_valid` gives a one-cycle DONE.
- Minimum frame time is `LENGTH*WIDTH + LENGTH + 3` cycles from `start` to returning to IDLE.
- Deasserting `rst_n` mid-frame clears everything immediately, asynchronously.

## Structure
- `rps_pkg` holds:
  - `LENGTH`, `WIDTH`, `LEFT`.
  - The six `LOWER/UPPER_GREEN_*` bounds.
  - `COL_W = $clog2(WIDTH)` and `ROW_W = $clog2(LENGTH)`.
  - The state enum `{IDLE, SCAN, STRIP, DONE}`.
- Sub-module `green_pixel_filter`: combinational, 24-bit pixel in, 1-bit `g` out. It is shared with the existing frame-level filter so the thresholds live in one place.
- The mask buffer is `LENGTH x WIDTH` flops, read by a column mux indexed by `res_leftmost`.

## Test plan
The bench uses `LENGTH`=4, `WIDTH`=6, `LEFT`=3. G is an in-range pixel; N has channel 0 outside its bound.
- **All-G frame:** `res_sum`=24, `res_sum_left`=12, `res_found`=1, `res_leftmost`=0, `res_strip`=4'b1111; `res_valid` rises 5 edges after the last pixel.
- **All-N frame:** `res_sum`=0, `res_sum_left`=0, `res_found`=0, `res_leftmost`=0, `res_strip`=0.
- **Hand only in column 4, rows 1 and 3:** `res_sum`=2, `res_sum_left`=0, `res_leftmost`=4, `res_strip`=4'b1010.
- **Random `pix_valid` gaps plus `res_ready` held low for 7 cycles:** results are identical to the gap-free run; `res_*` stay stable throughout DONE.
- **`abort` after 10 pixels, then a new `start` with an all-G frame:** results match the all-G case. A `start` pulsed during SCAN is ignored (the pixel count is unchanged).
- **`rst_n` asserted mid-STRIP:** all outputs are 0 immediately; a following frame completes normally.
